// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester memory port arbiter (fetch vs data)
//
// Shares one memory port between instruction fetch and data accesses.
// One transaction in flight at a time; data wins arbitration unless fetch has
// been passed over STREAK_MAX times in a row while it was waiting.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   i_valid/i_addr                  fetch request (held until i_addr_ok)
//   i_addr_ok/i_data_ok/i_data      fetch accept, completion, read data
//   d_valid/d_addr/d_size/
//   d_strobe/d_wdata                data request (strobe==0 means read)
//   d_addr_ok/d_data_ok/d_data      data accept, completion, read data
//   m_valid/m_is_write/m_addr/
//   m_size/m_strobe/m_wdata         memory request towards the bus
//   m_addr_ok/m_data_ok/m_rdata     memory accept, completion, read data
//   grant_d                         1 = current/last grant went to data
module mem_bus_arbiter #(
    parameter int STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_data,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [3:0]  d_strobe,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_data,
    output logic        m_valid,
    output logic        m_is_write,
    output logic [31:0] m_addr,
    output logic [2:0]  m_size,
    output logic [3:0]  m_strobe,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        grant_d
);

    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] streak;
    logic          take_d;
    logic          take_i;
    logic          accept;
    logic          done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_d     = 1'b0;
        take_i     = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                // Data normally wins; a saturated streak hands the port to a waiting fetch.
                if (d_valid && !(i_valid && streak == STREAK_TOP)) begin
                    take_d = 1'b1;
                end else if (i_valid) begin
                    take_i = 1'b1;
                end
                if (take_d || take_i) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (m_addr_ok) begin
                    accept = 1'b1;
                    // Memory may accept and complete in the same cycle.
                    if (m_data_ok) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (m_data_ok) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak     <= '0;
            grant_d    <= 1'b0;
            m_is_write <= 1'b0;
            m_addr     <= '0;
            m_size     <= '0;
            m_strobe   <= '0;
            m_wdata    <= '0;
        end else if (take_d) begin
            grant_d    <= 1'b1;
            m_is_write <= |d_strobe;
            m_addr     <= d_addr;
            m_size     <= d_size;
            m_strobe   <= d_strobe;
            m_wdata    <= d_wdata;
            // Only data grants that make fetch wait count towards the streak.
            if (i_valid && streak != STREAK_TOP) begin
                streak <= streak + 1'b1;
            end
        end else if (take_i) begin
            grant_d    <= 1'b0;
            m_is_write <= 1'b0;
            m_addr     <= i_addr;
            m_size     <= 3'b010;
            m_strobe   <= '0;
            m_wdata    <= '0;
            streak     <= '0;
        end
    end

    assign m_valid   = (state == REQ);

    assign i_addr_ok = accept && !grant_d;
    assign d_addr_ok = accept && grant_d;
    assign i_data_ok = done && !grant_d;
    assign d_data_ok = done && grant_d;
    assign i_data    = i_data_ok ? m_rdata : 32'h0;
    assign d_data    = d_data_ok ? m_rdata : 32'h0;

endmodule
